// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// the default display window bit, and the lane-alignment rules.
package lsu_pkg;

    localparam int DISPLAY_WORD_BIT_DEFAULT = 10;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        LD    = 3'd4,
        ERR   = 3'd5
    } state_e;

    // The reserved size code 2'b11 behaves exactly like a word access.
    function automatic size_e decodeSize(input logic [1:0] code);
        case (code)
            2'b00:   decodeSize = BYTE;
            2'b01:   decodeSize = HALF;
            default: decodeSize = WORD;
        endcase
    endfunction

    function automatic logic [1:0] alignOffset(input size_e size, input logic [1:0] off);
        case (size)
            BYTE:    alignOffset = off;
            HALF:    alignOffset = {off[1], 1'b0};
            default: alignOffset = 2'b00;
        endcase
    endfunction

    function automatic logic isMisaligned(input size_e size, input logic [1:0] off);
        case (size)
            BYTE:    isMisaligned = 1'b0;
            HALF:    isMisaligned = off[0];
            default: isMisaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends the loaded byte/halfword, and
// merges store data into a read word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_memWord,
    input  logic [31:0] i_storeWord,
    input  logic [1:0]  i_offset,
    input  size_e       i_size,
    input  logic        i_signed,
    output logic [31:0] o_loadData,
    output logic [31:0] o_mergeWord
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane select: byte lane n lives in bits [8n+7:8n].
    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_memWord[7:0];
            2'd1:    w_byte = i_memWord[15:8];
            2'd2:    w_byte = i_memWord[23:16];
            default: w_byte = i_memWord[31:24];
        endcase
        w_half = i_offset[1] ? i_memWord[31:16] : i_memWord[15:0];
        case (i_size)
            BYTE:    o_loadData = {{24{i_signed & w_byte[7]}}, w_byte};
            HALF:    o_loadData = {{16{i_signed & w_half[15]}}, w_half};
            default: o_loadData = i_memWord;
        endcase
    end

    always_comb begin
        o_mergeWord = i_memWord;
        case (i_size)
            BYTE: begin
                case (i_offset)
                    2'd0:    o_mergeWord[7:0]   = i_storeWord[7:0];
                    2'd1:    o_mergeWord[15:8]  = i_storeWord[7:0];
                    2'd2:    o_mergeWord[23:16] = i_storeWord[7:0];
                    default: o_mergeWord[31:24] = i_storeWord[7:0];
                endcase
            end
            HALF: begin
                if (i_offset[1]) begin
                    o_mergeWord[31:16] = i_storeWord[15:0];
                end else begin
                    o_mergeWord[15:0] = i_storeWord[15:0];
                end
            end
            default: o_mergeWord = i_storeWord;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM between the core and a word memory without byte enables.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int DISPLAY_WORD_BIT = DISPLAY_WORD_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    state_e      r_state;
    state_e      w_nextState;
    size_e       w_reqSize;
    size_e       r_size;
    logic [1:0]  w_reqOff;
    logic [1:0]  r_off;
    logic        r_signed;
    logic        r_we;
    logic [31:0] w_wordAddr;
    logic [31:0] r_memAddr;
    logic [31:0] r_wrWord;
    logic [31:0] w_loadData;
    logic [31:0] w_mergeWord;
    logic [31:0] r_rspRdata;
    logic        r_rspValid;
    logic        w_accept;
    logic        w_display;
    logic        w_misalign;
    logic        w_directWrite;

    assign w_accept      = req_valid_i && (r_state == IDLE);
    assign w_reqSize     = decodeSize(req_size_i);
    assign w_reqOff      = alignOffset(w_reqSize, req_addr_i[1:0]);
    assign w_wordAddr    = {2'b00, req_addr_i[31:2]};
    assign w_display     = w_wordAddr[DISPLAY_WORD_BIT];
    assign w_directWrite = (w_reqSize == WORD) || w_display;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = isMisaligned(w_reqSize, req_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    lsu_align u_align (
        .i_memWord   (mem_rdata_i),
        .i_storeWord (r_wrWord),
        .i_offset    (r_off),
        .i_size      (r_size),
        .i_signed    (r_signed),
        .o_loadData  (w_loadData),
        .o_mergeWord (w_mergeWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_nextState = ERR;
                    end else if (!req_we_i) begin
                        w_nextState = RD;
                    end else if (w_directWrite) begin
                        w_nextState = WR;
                    end else begin
                        w_nextState = RD;
                    end
                end
            end
            RD:      w_nextState = r_we ? MERGE : LD;
            MERGE:   w_nextState = WR;
            WR:      w_nextState = IDLE;
            LD:      w_nextState = IDLE;
            ERR:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Write strobe and data come straight from state so reset kills them at once.
    always_comb begin
        req_ready_o = (r_state == IDLE);
        mem_we_o    = (r_state == WR);
        mem_wdata_o = (r_state == WR) ? r_wrWord : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= BYTE;
            r_off      <= 2'b00;
            r_signed   <= 1'b0;
            r_we       <= 1'b0;
            r_memAddr  <= 32'h0;
            r_wrWord   <= 32'h0;
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_size   <= w_reqSize;
                r_off    <= w_reqOff;
                r_signed <= req_signed_i;
                r_we     <= req_we_i;
                r_wrWord <= w_display ? {24'h0, req_wdata_i[7:0]} : req_wdata_i;
                if (!w_misalign) begin
                    r_memAddr <= w_wordAddr;
                end
            end else if (r_state == MERGE) begin
                r_wrWord <= w_mergeWord;
            end
            r_rspValid <= (r_state == WR) || (r_state == LD) || (r_state == ERR);
            r_rspRdata <= (r_state == LD) ? w_loadData : 32'h0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_rspErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspErr <= 1'b0;
        end else begin
            r_rspErr <= (r_state == ERR);
        end
    end

    assign rsp_err_o = r_rspErr;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign rsp_valid_o = r_rspValid;
    assign rsp_rdata_o = r_rspRdata;
    assign mem_addr_o  = r_memAddr;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-level memory model plus per-cycle comparison of the
// response and memory-write ports, with hand-computed directed expectations.
module tb_lsu;

    localparam int DWB = 10;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    lsu #(.DISPLAY_WORD_BIT(DWB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct {
        int          at;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        isWrite;
        logic [31:0] wAddr;
        logic [31:0] wData;
    } exp_t;

    logic [31:0] mem [0:4095];
    logic [7:0]  refByte [0:16383];
    exp_t        expQ [$];
    int          checks;
    int          errors;
    int          cycleCnt;
    bit          compareEn;
    logic        expValid;
    logic        expWe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: one registered read cycle, write on strobe.
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[11:0]] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o[11:0]];
    end

    always @(posedge clk) cycleCnt = cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Transaction-level model over a byte-addressed memory image.
    function automatic exp_t modelAccess(input logic we, input logic [1:0] size, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int unsigned nb;
        int unsigned ea;
        int unsigned wa;
        logic [31:0] v;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        e.rdata = 32'h0;
        e.err = 1'b0;
        e.isWrite = 1'b0;
        e.wAddr = 32'h0;
        e.wData = 32'h0;
        e.at = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((addr % nb) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
`endif
        ea = addr & ~(nb - 1);
        wa = ea >> 2;
        if (we) begin
            if (((wa >> DWB) & 1) == 1) begin
                refByte[wa*4]   = wdata[7:0];
                refByte[wa*4+1] = 8'h00;
                refByte[wa*4+2] = 8'h00;
                refByte[wa*4+3] = 8'h00;
                e.lat = 1;
            end else begin
                for (int i = 0; i < int'(nb); i++) refByte[ea+i] = wdata[8*i +: 8];
                e.lat = (nb == 4) ? 1 : 3;
            end
            e.isWrite = 1'b1;
            e.wAddr = wa;
            e.wData = {refByte[wa*4+3], refByte[wa*4+2], refByte[wa*4+1], refByte[wa*4]};
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(nb); i++) v = v | (32'(refByte[ea+i]) << (8*i));
            if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 1);
            e.rdata = v;
            e.lat = 2;
        end
        return e;
    endfunction

    // Per-cycle comparison of the DUT ports against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (compareEn) begin
            expValid = (expQ.size() > 0) && (expQ[0].at == cycleCnt);
            expWe    = (expQ.size() > 0) && expQ[0].isWrite && (expQ[0].at - 1 == cycleCnt);
            checkOutput("cmp_rsp_valid", {31'h0, rsp_valid_o}, {31'h0, expValid});
            checkOutput("cmp_mem_we", {31'h0, mem_we_o}, {31'h0, expWe});
            if (expWe) begin
                checkOutput("cmp_mem_addr", mem_addr_o, expQ[0].wAddr);
                checkOutput("cmp_mem_wdata", mem_wdata_o, expQ[0].wData);
            end else begin
                checkOutput("cmp_mem_wdata_idle", mem_wdata_o, 32'h0);
            end
            if (expValid) begin
                checkOutput("cmp_rsp_rdata", rsp_rdata_o, expQ[0].rdata);
                checkOutput("cmp_rsp_err", {31'h0, rsp_err_o}, {31'h0, expQ[0].err});
                void'(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int expLat, input logic [31:0] expData, input logic expErr);
        exp_t e;
        int n;
        int lat;
        bit seen;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready_o) checkOutput({name, "_ready_timeout"}, 32'h0, 32'h1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_size_i   = size;
        req_signed_i = sgn;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        e = modelAccess(we, size, sgn, addr, wdata);
        e.at = cycleCnt + 1 + e.lat;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_o) begin
                seen = 1'b1;
                lat = k;
            end
        end
        if (!seen) begin
            checkOutput({name, "_rsp_timeout"}, 32'h0, 32'h1);
        end else begin
            checkOutput({name, "_latency"}, lat, expLat);
            checkOutput({name, "_rdata"}, rsp_rdata_o, expData);
            checkOutput({name, "_err"}, {31'h0, rsp_err_o}, {31'h0, expErr});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        cycleCnt = 0;
        compareEn = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) refByte[i] = 8'h00;
        mem_rdata_i  = 32'h0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_size_i   = 2'b00;
        req_signed_i = 1'b0;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        checkOutput("reset_ready", {31'h0, req_ready_o}, 32'h1);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata_o, 32'h0);
        checkOutput("reset_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        checkOutput("reset_mem_we", {31'h0, mem_we_o}, 32'h0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
        checkOutput("reset_mem_wdata", mem_wdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        compareEn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] word store / word load");
        applyStimulus("st_w_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
        applyStimulus("ld_w_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        $display("[TB] byte store read-modify-write and sub-word loads");
        applyStimulus("st_b_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 3, 32'h0, 1'b0);
        checkOutput("mem_word4_after_byte", mem[4], 32'hDEADAAEF);
        applyStimulus("ld_bs_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 32'hFFFFFFAA, 1'b0);
        applyStimulus("ld_bu_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 32'h000000AA, 1'b0);
        applyStimulus("ld_hs_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'hFFFFDEAD, 1'b0);
        applyStimulus("ld_hu_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'h0000DEAD, 1'b0);

        $display("[TB] misaligned word load");
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus("ld_w_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        checkOutput("trap_no_addr_change", mem_addr_o, 32'h4);
`else
        applyStimulus("ld_w_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 2, 32'hDEADAAEF, 1'b0);
`endif

        $display("[TB] display window store and load");
        applyStimulus("st_disp", 1'b1, 2'b00, 1'b0, 32'h1003, 32'h1234565A, 1, 32'h0, 1'b0);
        checkOutput("mem_disp_word", mem[12'h400], 32'h0000005A);
        applyStimulus("ld_disp", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 2, 32'h0000005A, 1'b0);

        $display("[TB] halfword store and size code 3");
        applyStimulus("st_h_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 3, 32'h0, 1'b0);
        applyStimulus("ld_hu_16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 2, 32'h00001234, 1'b0);
        applyStimulus("ld_w_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'h12340000, 1'b0);
        applyStimulus("ld_sz3_10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2, 32'hDEADAAEF, 1'b0);

        $display("[TB] reset during merge");
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_size_i   = 2'b00;
        req_signed_i = 1'b0;
        req_addr_i   = 32'h11;
        req_wdata_i  = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_we", {31'h0, mem_we_o}, 32'h0);
        checkOutput("abort_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_ready", {31'h0, req_ready_o}, 32'h1);
        checkOutput("abort_mem_word4", mem[4], 32'hDEADAAEF);
        applyStimulus("ld_w_10_post", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADAAEF, 1'b0);

        $display("[TB] misaligned halfword store");
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus("st_h_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF, 1, 32'h0, 1'b1);
        applyStimulus("ld_w_10_end", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADAAEF, 1'b0);
`else
        applyStimulus("st_h_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF, 3, 32'h0, 1'b0);
        applyStimulus("ld_w_10_end", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the CPU core's execute stage and the data port of the single-ported-per-side word memory. Accepts byte-addressed load/store requests of byte, halfword or word size via a valid/ready handshake and turns them into word-addressed memory transactions, with one registered read cycle. Sub-word stores to RAM use read-modify-write because the memory has no byte enables. Stores to the display window go straight through with no read.

## Interface
Parameters:
- `DISPLAY_WORD_BIT`, default 10: word-address bit that selects the display register instead of RAM.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: LSU can accept; high only in IDLE.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_signed_i` in 1: sign-extend sub-word loads.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-justified.
- `rsp_valid_o` out 1: one-cycle completion pulse for loads and stores.
- `rsp_rdata_o` out 32: load result, extended; 0 for stores.
- `rsp_err_o` out 1: misaligned access (see Configuration).
- `mem_addr_o` out 32: word address = {2'b00, addr[31:2]}.
- `mem_we_o` out 1: memory write strobe.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory read data, valid the cycle after `mem_addr_o` is presented.

## Operation
- States: IDLE, RD, MERGE, WR, LD.
- IDLE: `req_ready_o`=1. On `req_valid_i`&`req_ready_o`, register addr, size, signed, we and wdata.
- From IDLE on accept:
  - Load → RD.
  - Word store or display store → WR.
  - Sub-word RAM store → RD.
- RD: drive `mem_addr_o`. Next state is LD for a load, MERGE for a sub-word store.
- LD: `mem_rdata_i` valid. Select the lane at addr[1:0]: byte lanes 0..3, halfword lanes 0/2, little-endian. Zero- or sign-extend, register into `rsp_rdata_o`, pulse `rsp_valid_o`, go to IDLE.
- MERGE: replace the addressed byte or halfword of `mem_rdata_i` with the low bits of the store data, register as the write word, go to WR.
- WR: `mem_we_o`=1 with `mem_addr_o` and `mem_wdata_o` stable. At the edge: pulse `rsp_valid_o`, go to IDLE.
- Display store (word address bit `DISPLAY_WORD_BIT` set): `mem_wdata_o`[7:0] = `req_wdata_i`[7:0] for every size and offset; never a read.
- Loads from the display window read through normally.
- `mem_we_o` is asserted only in WR.
- `mem_addr_o` holds its last value outside active states; `mem_wdata_o` is 0 except in WR.
- A request asserted while `req_ready_o`=0 is not accepted and must be held by the core.

## Timing
- Accept edge is N. `rsp_valid_o` is high for one cycle, registered at:
  - word or display store: edge N+1;
  - load: edge N+2;
  - sub-word RAM store: edge N+3;
  - misaligned error with trap enabled: edge N+1.
- `req_ready_o` rises in the same cycle as `rsp_valid_o`, so back-to-back acceptance is possible.
- Reset values: state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- Reset mid-operation aborts immediately:
  - `mem_we_o` drops asynchronously;
  - no response is produced;
  - a partially merged RMW is never written.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, is rejected. No memory access occurs; response is `rsp_err_o`=1, `rsp_rdata_o`=0, at N+1.
- Undefined: the low address bits are forced to alignment (halfword clears bit 0, word clears bits 1:0) and the access proceeds. `rsp_err_o` is tied to 0.

## Structure
- `lsu_pkg`: size enum (BYTE, HALF, WORD), state enum, `DISPLAY_WORD_BIT` default constant.
- Sub-module `lsu_align`: combinational load-lane extraction with extension, plus store-lane merge. `lsu` holds only the FSM and registers.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → store rsp at N+1 with one `mem_we_o` cycle at `mem_addr_o`=0x4; load rsp at N+2 with 0xDEADBEEF.
- Byte store 0xAA @0x11 → RD, MERGE, WR; memory word = 0xDEADAAEF; rsp at N+3. Then:
  - signed byte load @0x11 → 0xFFFFFFAA;
  - unsigned → 0x000000AA.
- Signed halfword load @0x12 → 0xFFFFDEAD; unsigned → 0x0000DEAD.
- With the macro, word load @0x13 → `rsp_err_o`=1, `rsp_rdata_o`=0, rsp at N+1, no memory activity. Without the macro → reads word 0x4.
- Byte store 0x5A @0x1003 → single WR cycle, `mem_addr_o`=0x400, `mem_wdata_o`=0x0000005A, no RD state.
- `rst_n` low during MERGE → `mem_we_o` stays 0, no `rsp_valid_o`; after release `req_ready_o`=1 and the memory word is unchanged.
